uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter; successor to the fixed 8N1 Tx FSM.
//  Serialises a DATA_BITS word: start bit, data LSB first, optional parity, 1 or 2 stop bits.
//  Bit timing comes from an internal clock-divider (CLKS_PER_BIT); no external baud tick.
//  Sits between a byte producer (CPU regs / FIFO) and the tx pad.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); legal >= 2
//  DATA_BITS     8    data bits per frame; legal 5..9
//  PARITY_MODE   0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
// PORTS
//  clk       in   1          system clock, rising edge
//  rst       in   1          reset, asynchronous, active-low
//  tx_start  in   1          request to send to_tx; sampled only when tx_ready=1
//  to_tx     in   DATA_BITS  data word, captured on the accepting edge
//  tx_ready  out  1          1 = a tx_start on this edge is accepted
//  busy      out  1          1 = frame in progress (start bit through last stop bit)
//  tx_done   out  1          1-cycle pulse in the last clk of the last stop bit
//  tx_out    out  1          serial line, idle high
// BEHAVIOUR
//  Reset (rst=0, async): tx_out=1, busy=0, tx_done=0, tx_ready=1, FSM=IDLE, counters=0.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or -> START, hold option).
//  Accept: tx_start=1 & tx_ready=1 at posedge -> to_tx latched into shift reg;
//   next cycle state=START, tx_out=0, busy=1 (latency 1 clk).
//  Each bit is driven for exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1,
//   bit advances on terminal count, counter reloads to 0 on every accept.
//  DATA: bit index 0..DATA_BITS-1, tx_out = shift[0], shift right each bit.
//  PARITY (PARITY_MODE!=0): bit = ^data for even, ~^data for odd (computed on latched word).
//  STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 in its final cycle.
//  Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) clks.
//  After STOP (no pending word): IDLE, busy=0, tx_ready=1 on the cycle after tx_done.
//  tx_start while tx_ready=0: ignored, no error flag, current frame unaffected.
//  to_tx changes after acceptance: no effect on the frame in flight.
//  Reset mid-frame: frame aborted, tx_out=1 immediately; no tx_done pulse.
//  Illegal parameter values: elaboration-time $error / generate failure.
// CONFIGURATION
//  Macro UART_TX_HOLD_EN:
//   defined   - 1-entry holding register; tx_ready = ~hold_valid (high while busy if empty).
//               Word accepted during a frame is held; at end of STOP go straight to START
//               next cycle: zero idle cycles between frames, busy stays 1, tx_done still pulses.
//               Simultaneous accept and end-of-STOP with empty hold: word goes direct to START.
//   undefined - no holding register; tx_ready = ~busy; minimum one idle cycle between frames.
// STRUCTURE
//  uart_pkg: state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP),
//   parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), clog2 helper for counter widths.
//  Sub-module uart_baud_gen: counter with sync clear, outputs bit_tick at terminal count;
//   reusable by the future Rx block (with half-bit offset input).
//  Top holds FSM, shift register, bit/stop counters, parity, optional hold register.
// TESTING  (bench uses CLKS_PER_BIT=4; line checker samples tx_out mid-bit)
//  1 Reset: rst=0 mid-run -> tx_out=1, busy=0, tx_ready=1, tx_done=0 without a clk edge.
//  2 8N1, to_tx=8'h55 -> tx_out 0,1,0,1,0,1,0,1,0,1 each 4 clks; busy=1 for 40 clks; one tx_done.
//  3 PARITY_MODE=2, STOP_BITS=2, to_tx=8'hAA -> data 0,1,0,1,0,1,0,1, parity 0, two stop 1s; 48 clks.
//  4 DATA_BITS=7, PARITY_MODE=1, to_tx=7'h7F -> seven 1s, parity bit 0; 40 clks frame.
//  5 tx_start=1 with 8'hF0 while busy -> no HOLD: ignored, line shows only first frame;
//    HOLD_EN: F0 frame starts the cycle after tx_done, busy never drops, 0 idle cycles.
//  6 rst=0 during DATA bit 3 of 8'h55, release, send 8'hAA -> clean AA frame, no tx_done for 55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and a
// ceiling-log2 helper used to size counters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled, pulses o_bit_tick
// on terminal count. i_half selects a half-bit period for receiver alignment.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_half,
  output logic o_bit_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term;

  assign w_term     = i_half ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1);
  assign o_bit_tick = i_en & (r_cnt == w_term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stops.
// Define UART_TX_HOLD_EN to add a one-word holding register for back-to-back frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] to_tx,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 tx_out
);

  localparam int BIT_W = clog2(DATA_BITS);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  uart_state_t          r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_load_data;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_par;
  logic                 w_par_calc;
  logic                 w_tick, w_accept, w_load;
  logic                 w_last_bit, w_last_stop, w_done;

  assign busy        = (r_state != ST_IDLE);
  assign w_accept    = tx_start & tx_ready;
  assign w_last_bit  = (r_bit_idx == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_done      = (r_state == ST_STOP) & w_tick & w_last_stop;
  assign tx_done     = w_done;
  assign w_par_calc  = (PARITY_MODE == PAR_EVEN) ? ^w_load_data : ~^w_load_data;

`ifdef UART_TX_HOLD_EN
  logic                 r_hold_valid;
  logic [DATA_BITS-1:0] r_hold_data;
  logic                 w_load_direct;

  // A word arriving while idle or exactly at end of frame bypasses the hold slot.
  assign tx_ready      = ~r_hold_valid;
  assign w_load_direct = w_accept & (~busy | w_done);
  assign w_load        = w_load_direct | (w_done & r_hold_valid);
  assign w_load_data   = r_hold_valid ? r_hold_data : to_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_accept && !w_load_direct) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= to_tx;
    end else if (w_done) begin
      r_hold_valid <= 1'b0;
    end
  end
`else
  assign tx_ready    = ~busy;
  assign w_load      = w_accept;
  assign w_load_data = to_tx;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_en      (busy),
    .i_clr     (w_load | ~busy),
    .i_half    (1'b0),
    .o_bit_tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_load) w_state_next = ST_START;
      ST_START:  if (w_tick) w_state_next = ST_DATA;
      ST_DATA:   if (w_tick && w_last_bit)
                   w_state_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tick) w_state_next = ST_STOP;
      ST_STOP:   if (w_done) w_state_next = w_load ? ST_START : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
    end else if (w_load) begin
      r_shift    <= w_load_data;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= w_par_calc;
    end else if (w_tick) begin
      if (r_state == ST_DATA) begin
        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + BIT_W'(1);
      end
      if (r_state == ST_STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (r_state)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = r_shift[0];
      ST_PARITY: tx_out = r_par;
      default:   tx_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 8E2, 7O1) at 4 clks/bit, a mid-bit
// line checker feeding a frame scoreboard, and directed steps incl. reset abort.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       stt[3];
  logic [8:0] dat[3];
  logic       txo[3], bsy[3], rdy[3], dn[3];

  int total = 0;
  int bad   = 0;

  int nb[3]   = '{10, 12, 10};
  int nd_a[3] = '{8, 8, 7};
  int pm_a[3] = '{0, 2, 1};

  logic [11:0] q0[$], q1[$], q2[$];
  int          done_cnt[3], busy_run[3], last_busy[3], c[3];
  bit          act[3];
  logic [11:0] frame[3];

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst_n), .tx_start(stt[0]), .to_tx(dat[0][7:0]),
    .tx_ready(rdy[0]), .busy(bsy[0]), .tx_done(dn[0]), .tx_out(txo[0]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst_n), .tx_start(stt[1]), .to_tx(dat[1][7:0]),
    .tx_ready(rdy[1]), .busy(bsy[1]), .tx_done(dn[1]), .tx_out(txo[1]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst(rst_n), .tx_start(stt[2]), .to_tx(dat[2][6:0]),
    .tx_ready(rdy[2]), .busy(bsy[2]), .tx_done(dn[2]), .tx_out(txo[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line bits in order: start, data LSB first, parity if any; remaining bits are stop/idle ones.
  function automatic logic [11:0] mk(input logic [8:0] d, input int nd, input int pm);
    logic [11:0] f;
    logic        p;
    int          k;
    f = '1; f[0] = 1'b0; k = 1; p = 1'b0;
    for (int j = 0; j < nd; j++) begin
      f[k] = d[j];
      p    = p ^ d[j];
      k++;
    end
    if (pm == 2) f[k] = p;
    else if (pm == 1) f[k] = ~p;
    return f;
  endfunction

  function automatic void push_exp(input int i, input logic [11:0] f);
    case (i)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic bit pop_exp(input int i, output logic [11:0] f);
    f = '1;
    case (i)
      0:       begin if (q0.size() == 0) return 1'b0; f = q0.pop_front(); end
      1:       begin if (q1.size() == 0) return 1'b0; f = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 1'b0; f = q2.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  always @(negedge clk) begin : line_mon
    logic [11:0] ef;
    for (int i = 0; i < 3; i++) begin
      if (rst_n !== 1'b1) begin
        act[i]      = 1'b0;
        busy_run[i] = 0;
      end else begin
        if (dn[i] === 1'b1) done_cnt[i]++;
        if (bsy[i] === 1'b1) busy_run[i]++;
        else if (busy_run[i] != 0) begin
          last_busy[i] = busy_run[i];
          busy_run[i]  = 0;
        end
        if (!act[i] && txo[i] === 1'b0) begin
          act[i]   = 1'b1;
          c[i]     = 0;
          frame[i] = '1;
        end
        if (act[i]) begin
          if (c[i] % CPB == CPB / 2) frame[i][c[i] / CPB] = txo[i];
          if (c[i] == (nb[i] - 1) * CPB + CPB / 2) begin
            act[i] = 1'b0;
            if (pop_exp(i, ef)) chk($sformatf("frame%0d", i), 32'(frame[i]), 32'(ef));
            else chk($sformatf("unexpected_frame%0d", i), 32'(frame[i]), 32'hFFF);
          end
          c[i]++;
        end
      end
    end
  end

  task automatic send(input int i, input logic [8:0] d);
    @(negedge clk);
    stt[i] = 1'b1;
    dat[i] = d;
    push_exp(i, mk(d, nd_a[i], pm_a[i]));
    @(negedge clk);
    stt[i] = 1'b0;
    dat[i] = ~d;
    #1;
    chk($sformatf("lat_txo%0d", i), 32'(txo[i]), 32'd0);
    chk($sformatf("lat_busy%0d", i), 32'(bsy[i]), 32'd1);
  endtask

  task automatic wait_done(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt[i] < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("done_wait%0d", i), 32'(done_cnt[i]), 32'(n));
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stt[i] = 1'b0;
      dat[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txo", 32'(txo[0]), 32'd1);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_done", 32'(dn[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1 0x55
    send(0, 9'h055);
    chk("t2_ready_busy", 32'(rdy[0]), 32'd0);
    wait_done(0, 1, 200);
    @(negedge clk); #1;
    chk("t2_busy_len", 32'(last_busy[0]), 32'd40);
    chk("t2_ready_after", 32'(rdy[0]), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt[0]), 32'd1);

    // 8E2 0xAA
    send(1, 9'h0AA);
    wait_done(1, 1, 200);
    @(negedge clk); #1;
    chk("t3_busy_len", 32'(last_busy[1]), 32'd48);
    chk("t3_ready_after", 32'(rdy[1]), 32'd1);

    // 7O1 0x7F
    send(2, 9'h07F);
    wait_done(2, 1, 200);
    @(negedge clk); #1;
    chk("t4_busy_len", 32'(last_busy[2]), 32'd40);

    // start request during a frame
    base = done_cnt[0];
    send(0, 9'h055);
    repeat (8) @(negedge clk);
    stt[0] = 1'b1;
    dat[0] = 9'h0F0;
    #1;
`ifdef UART_TX_HOLD_EN
    chk("t5_ready_hold_empty", 32'(rdy[0]), 32'd1);
    push_exp(0, mk(9'h0F0, 8, 0));
`else
    chk("t5_ready_busy", 32'(rdy[0]), 32'd0);
`endif
    repeat (4) @(negedge clk);
    stt[0] = 1'b0;
    #1;
    chk("t5_ready_mid", 32'(rdy[0]), 32'd0);
`ifdef UART_TX_HOLD_EN
    wait_done(0, base + 2, 300);
    @(negedge clk); #1;
    chk("t5_busy_len_b2b", 32'(last_busy[0]), 32'd80);
`else
    wait_done(0, base + 1, 200);
    repeat (60) @(negedge clk);
    #1;
    chk("t5_no_extra_done", 32'(done_cnt[0]), 32'(base + 1));
    chk("t5_busy_len", 32'(last_busy[0]), 32'd40);
`endif

    // reset during data bit 3 of 0x55, then a clean 0xAA frame
    base = done_cnt[0];
    send(0, 9'h055);
    repeat (17) @(negedge clk);
    #1;
    chk("t6_bit3", 32'(txo[0]), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_txo", 32'(txo[0]), 32'd1);
    chk("t6_rst_busy", 32'(bsy[0]), 32'd0);
    chk("t6_rst_ready", 32'(rdy[0]), 32'd1);
    chk("t6_rst_done", 32'(dn[0]), 32'd0);
    if (q0.size() != 0) void'(q0.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_no_done_aborted", 32'(done_cnt[0]), 32'(base));
    send(0, 9'h0AA);
    wait_done(0, base + 1, 200);
    @(negedge clk); #1;
    chk("t6_busy_len", 32'(last_busy[0]), 32'd40);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
